product_accumulator: RTL and testbench

- Downstream consumer of the unsigned `multiplier` stage.
- Sums a group of consecutive `product` values into one wide result.
- A group closes after ACC_LEN accepted terms or on an early `in_last`.
- The finished sum is held in a one-entry output register with a valid/ready handshake, so the multiplier pipeline can be stalled by the sink.

---
 rtl/product_accumulator.sv | 128 ++++++++++++
 tb/tb_product_accumulator.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
//
// Sums groups of consecutive unsigned products from the upstream multiplier
// into one wide result. A group closes after ACC_LEN accepted terms, or
// earlier when a term arrives with in_last set. The finished sum is held in a
// one-entry output register with a valid/ready handshake. While that register
// is full and the sink is not ready, the block stalls the multiplier.
//
// Ports:
//   clk        rising-edge clock, single clock domain
//   rst_n      asynchronous active-low reset
//   product    unsigned term from the multiplier (2*DATAWIDTH bits)
//   in_valid   product is valid this cycle
//   in_last    qualifies in_valid; this term closes the group early
//   in_ready   block accepts product this cycle
//   out_sum    completed group sum (ACCWIDTH bits, zero-extended arithmetic)
//   out_count  number of terms in out_sum (1..ACC_LEN)
//   out_valid  out_sum/out_count are valid
//   out_ready  sink consumes the result this cycle
// ---------------------------------------------------------------------------
module product_accumulator #(
  parameter int DATAWIDTH = 14,
  parameter int ACC_LEN   = 16,
  parameter int ACCWIDTH  = 2*DATAWIDTH+4,
  parameter int CNTWIDTH  = $clog2(ACC_LEN+1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2*DATAWIDTH-1:0] product,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [ACCWIDTH-1:0]    out_sum,
  output logic [CNTWIDTH-1:0]    out_count,
  output logic                   out_valid,
  input  logic                   out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [ACCWIDTH-1:0] acc;
  logic [ACCWIDTH-1:0] acc_next;
  logic [ACCWIDTH-1:0] out_sum_next;
  logic [ACCWIDTH-1:0] term;
  logic [ACCWIDTH-1:0] sum;
  logic [CNTWIDTH-1:0] cnt;
  logic [CNTWIDTH-1:0] cnt_next;
  logic [CNTWIDTH-1:0] cnt_inc;
  logic [CNTWIDTH-1:0] out_count_next;
  logic                accept;
  logic                closing;

  // In HOLD the block can only take a new term when the held result drains
  // in the same cycle; in_ready is kept low while reset is asserted.
  assign in_ready  = rst_n && ((state != HOLD) || out_ready);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;

  // acc and cnt are cleared whenever a group closes, so in IDLE and HOLD
  // these expressions reduce to "start a new group with this term".
  assign term    = ACCWIDTH'(product);
  assign sum     = acc + term;
  assign cnt_inc = cnt + CNTWIDTH'(1);
  assign closing = in_last || (cnt_inc == CNTWIDTH'(ACC_LEN));

  // Next-state and datapath selection. An accepted term either extends the
  // running group or closes it into the output register; HOLD without a new
  // term returns to IDLE once the sink takes the result.
  always_comb begin
    state_next     = state;
    acc_next       = acc;
    cnt_next       = cnt;
    out_sum_next   = out_sum;
    out_count_next = out_count;

    unique case (state)
      IDLE, ACCUM, HOLD: begin
        if (accept) begin
          if (closing) begin
            out_sum_next   = sum;
            out_count_next = cnt_inc;
            acc_next       = '0;
            cnt_next       = '0;
            state_next     = HOLD;
          end else begin
            acc_next   = sum;
            cnt_next   = cnt_inc;
            state_next = ACCUM;
          end
        end else if ((state == HOLD) && out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        acc_next   = '0;
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial group and any
  // held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_sum   <= '0;
      out_count <= '0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      cnt       <= cnt_next;
      out_sum   <= out_sum_next;
      out_count <= out_count_next;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_product_accumulator
//
// Directed bench for product_accumulator with the default parameters
// (DATAWIDTH=14, ACC_LEN=16, ACCWIDTH=32, CNTWIDTH=5). A table of per-cycle
// vectors covers early closes and back-to-back groups; hand-written sequences
// cover full groups, worst-case width, backpressure and reset.
// ---------------------------------------------------------------------------
module tb_product_accumulator;

  localparam int DATAWIDTH = 14;
  localparam int ACC_LEN   = 16;
  localparam int ACCWIDTH  = 2*DATAWIDTH+4;
  localparam int CNTWIDTH  = $clog2(ACC_LEN+1);

  logic                   clk;
  logic                   rst_n;
  logic [2*DATAWIDTH-1:0] product;
  logic                   in_valid;
  logic                   in_last;
  logic                   in_ready;
  logic [ACCWIDTH-1:0]    out_sum;
  logic [CNTWIDTH-1:0]    out_count;
  logic                   out_valid;
  logic                   out_ready;

  int checks;
  int errors;

  typedef struct {
    logic                   valid;
    logic                   last;
    logic [2*DATAWIDTH-1:0] prod;
    logic                   oready;
    logic                   exp_ready;
    logic                   exp_valid;
    logic [ACCWIDTH-1:0]    exp_sum;
    logic [CNTWIDTH-1:0]    exp_count;
  } vec_t;

  vec_t vecs[14];

  product_accumulator #(
    .DATAWIDTH(DATAWIDTH),
    .ACC_LEN  (ACC_LEN),
    .ACCWIDTH (ACCWIDTH),
    .CNTWIDTH (CNTWIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .product  (product),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_sum  (out_sum),
    .out_count(out_count),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle's inputs and let combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic l,
                               input logic [2*DATAWIDTH-1:0] p,
                               input logic r);
    in_valid  = v;
    in_last   = l;
    product   = p;
    out_ready = r;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // One full cycle: drive, check in_ready before the edge, clock, then check
  // the registered outputs. Sum/count are only meaningful while out_valid=1.
  task automatic runBeat(input string name, input logic v, input logic l,
                         input logic [2*DATAWIDTH-1:0] p, input logic r,
                         input logic exp_ready, input logic exp_valid,
                         input logic [ACCWIDTH-1:0] exp_sum,
                         input logic [CNTWIDTH-1:0] exp_count);
    applyStimulus(v, l, p, r);
    checkOutput({name, "_in_ready"}, 64'(in_ready), 64'(exp_ready));
    tick();
    checkOutput({name, "_out_valid"}, 64'(out_valid), 64'(exp_valid));
    if (exp_valid) begin
      checkOutput({name, "_out_sum"}, 64'(out_sum), 64'(exp_sum));
      checkOutput({name, "_out_count"}, 64'(out_count), 64'(exp_count));
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    product   = '0;
    out_ready = 1'b0;

    // Early-close table: {valid,last,prod,oready, exp_ready,exp_valid,sum,count}
    vecs[0]  = '{1'b1, 1'b0, 28'd10,  1'b1, 1'b1, 1'b0, 32'd0,   5'd0};
    vecs[1]  = '{1'b1, 1'b0, 28'd20,  1'b1, 1'b1, 1'b0, 32'd0,   5'd0};
    vecs[2]  = '{1'b1, 1'b1, 28'd30,  1'b1, 1'b1, 1'b1, 32'd60,  5'd3};
    vecs[3]  = '{1'b1, 1'b1, 28'd7,   1'b1, 1'b1, 1'b1, 32'd7,   5'd1};
    vecs[4]  = '{1'b0, 1'b1, 28'd999, 1'b1, 1'b1, 1'b0, 32'd0,   5'd0};
    vecs[5]  = '{1'b0, 1'b0, 28'd0,   1'b1, 1'b1, 1'b0, 32'd0,   5'd0};
    vecs[6]  = '{1'b1, 1'b1, 28'd5,   1'b1, 1'b1, 1'b1, 32'd5,   5'd1};
    vecs[7]  = '{1'b1, 1'b0, 28'd3,   1'b1, 1'b1, 1'b0, 32'd0,   5'd0};
    vecs[8]  = '{1'b1, 1'b1, 28'd4,   1'b1, 1'b1, 1'b1, 32'd7,   5'd2};
    vecs[9]  = '{1'b1, 1'b0, 28'd2,   1'b0, 1'b0, 1'b1, 32'd7,   5'd2};
    vecs[10] = '{1'b1, 1'b0, 28'd2,   1'b1, 1'b1, 1'b0, 32'd0,   5'd0};
    vecs[11] = '{1'b0, 1'b0, 28'd0,   1'b1, 1'b1, 1'b0, 32'd0,   5'd0};
    vecs[12] = '{1'b1, 1'b1, 28'd1,   1'b1, 1'b1, 1'b1, 32'd3,   5'd2};
    vecs[13] = '{1'b0, 1'b0, 28'd0,   1'b1, 1'b1, 1'b0, 32'd0,   5'd0};

    // Reset state, before any clock edge.
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_sum", 64'(out_sum), 64'd0);
    checkOutput("rst_out_count", 64'(out_count), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("rel_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rel_out_valid", 64'(out_valid), 64'd0);

    // Full group of 16 x 1020.
    for (int i = 0; i < ACC_LEN; i++)
      runBeat($sformatf("full%0d", i), 1'b1, 1'b0, 28'd1020, 1'b1,
              1'b1, (i == ACC_LEN-1), 32'd16320, 5'd16);
    runBeat("full_after", 1'b0, 1'b0, 28'd0, 1'b1, 1'b1, 1'b0, 32'd0, 5'd0);

    // Early closes, back-to-back groups, stall inside the table.
    for (int i = 0; i < 14; i++)
      runBeat($sformatf("vec%0d", i), vecs[i].valid, vecs[i].last,
              vecs[i].prod, vecs[i].oready, vecs[i].exp_ready,
              vecs[i].exp_valid, vecs[i].exp_sum, vecs[i].exp_count);

    // in_last on the 16th term closes once.
    for (int i = 0; i < ACC_LEN; i++)
      runBeat($sformatf("lastlen%0d", i), 1'b1, (i == ACC_LEN-1), 28'd1, 1'b1,
              1'b1, (i == ACC_LEN-1), 32'd16, 5'd16);
    runBeat("lastlen_after", 1'b0, 1'b0, 28'd0, 1'b1, 1'b1, 1'b0, 32'd0, 5'd0);

    // Worst-case width: 16 x (2**14-1)**2.
    for (int i = 0; i < ACC_LEN; i++)
      runBeat($sformatf("wide%0d", i), 1'b1, 1'b0, 28'd268402689, 1'b1,
              1'b1, (i == ACC_LEN-1), 32'd4294443024, 5'd16);
    runBeat("wide_after", 1'b0, 1'b0, 28'd0, 1'b1, 1'b1, 1'b0, 32'd0, 5'd0);

    // Backpressure: close 1+2+3 with the sink stalled, hold for 5 cycles
    // while a beat of 50 waits, then drain and take it in the same cycle.
    runBeat("bp_a", 1'b1, 1'b0, 28'd1, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0);
    runBeat("bp_b", 1'b1, 1'b0, 28'd2, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0);
    runBeat("bp_c", 1'b1, 1'b1, 28'd3, 1'b0, 1'b1, 1'b1, 32'd6, 5'd3);
    for (int i = 0; i < 5; i++)
      runBeat($sformatf("bp_stall%0d", i), 1'b1, 1'b0, 28'd50, 1'b0,
              1'b0, 1'b1, 32'd6, 5'd3);
    runBeat("bp_drain", 1'b1, 1'b0, 28'd50, 1'b1, 1'b1, 1'b0, 32'd0, 5'd0);
    runBeat("bp_next", 1'b1, 1'b1, 28'd60, 1'b1, 1'b1, 1'b1, 32'd110, 5'd2);
    runBeat("bp_hold", 1'b0, 1'b0, 28'd0, 1'b0, 1'b0, 1'b1, 32'd110, 5'd2);

    // Asynchronous reset mid-cycle while a result is held.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("arst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("arst_out_sum", 64'(out_sum), 64'd0);
    checkOutput("arst_out_count", 64'(out_count), 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("arst_rel_in_ready", 64'(in_ready), 64'd1);

    // Mid-group reset: 8 x 100 discarded, then 16 x 1 gives the only result.
    for (int i = 0; i < 8; i++)
      runBeat($sformatf("mid%0d", i), 1'b1, 1'b0, 28'd100, 1'b1,
              1'b1, 1'b0, 32'd0, 5'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < ACC_LEN; i++)
      runBeat($sformatf("post%0d", i), 1'b1, 1'b0, 28'd1, 1'b1,
              1'b1, (i == ACC_LEN-1), 32'd16, 5'd16);
    runBeat("post_after", 1'b0, 1'b0, 28'd0, 1'b1, 1'b1, 1'b0, 32'd0, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
